// File: rtl/alu_pkg.sv
// Shared types for the sequential RV32I/RV32M ALU: operation codes, decode
// selectors, func7 constants, FSM states and small decode helpers.
package alu_pkg;

    // Low four bits keep the legacy single-cycle ALU encodings (AND/OR/ADD/SUB).
    // Bit 4 marks M-extension ops; their low three bits equal func3.
    typedef enum logic [4:0] {
        ALU_AND    = 5'b00000,
        ALU_OR     = 5'b00001,
        ALU_ADD    = 5'b00010,
        ALU_SLL    = 5'b00011,
        ALU_SLT    = 5'b00100,
        ALU_SLTU   = 5'b00101,
        ALU_SUB    = 5'b00110,
        ALU_XOR    = 5'b00111,
        ALU_SRL    = 5'b01000,
        ALU_SRA    = 5'b01001,
        ALU_MUL    = 5'b10000,
        ALU_MULH   = 5'b10001,
        ALU_MULHSU = 5'b10010,
        ALU_MULHU  = 5'b10011,
        ALU_DIV    = 5'b10100,
        ALU_DIVU   = 5'b10101,
        ALU_REM    = 5'b10110,
        ALU_REMU   = 5'b10111
    } alu_op_e;

    typedef enum logic [1:0] {
        AOP_LOAD_STORE = 2'b00,
        AOP_BRANCH     = 2'b01,
        AOP_R_TYPE     = 2'b10,
        AOP_I_TYPE     = 2'b11
    } alu_op_t;

    localparam logic [6:0] F7_BASE   = 7'b0000000;
    localparam logic [6:0] F7_ALT    = 7'b0100000;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

    // Base-ISA op selected by func3 alone (func7 = F7_BASE flavour).
    function automatic alu_op_e base_op(input logic [2:0] func3);
        case (func3)
            3'b000:  return ALU_ADD;
            3'b001:  return ALU_SLL;
            3'b010:  return ALU_SLT;
            3'b011:  return ALU_SLTU;
            3'b100:  return ALU_XOR;
            3'b101:  return ALU_SRL;
            3'b110:  return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

    // True for DIV/DIVU/REM/REMU.
    function automatic logic is_div(input alu_op_e code);
        return code[4] && code[2];
    endfunction

endpackage

// File: rtl/alu_md_decode.sv
// Combinational decode of {alu_op, func7, func3} into an ALU operation code,
// a multi-cycle flag and an illegal-combination flag.
module alu_md_decode
    import alu_pkg::*;
#(
    parameter int EN_M = 1
) (
    input  logic [1:0] alu_op,
    input  logic [6:0] func7,
    input  logic [2:0] func3,
    output alu_op_e    code,
    output logic       is_multi,
    output logic       illegal
);

    // Map the instruction fields to an op; anything undecodable is flagged.
    always_comb begin
        // NOTE: every output gets a default before the case so no path leaves
        // it unassigned, which would otherwise infer a latch.
        code     = ALU_ADD;
        illegal  = 1'b0;
        case (alu_op_t'(alu_op))
            AOP_LOAD_STORE: code = ALU_ADD;
            AOP_BRANCH:     code = ALU_SUB;
            AOP_R_TYPE: begin
                if (func7 == F7_BASE)
                    code = base_op(func3);
                else if (func7 == F7_ALT && func3 == 3'b000)
                    code = ALU_SUB;
                else if (func7 == F7_ALT && func3 == 3'b101)
                    code = ALU_SRA;
                else if (func7 == F7_MULDIV && EN_M != 0)
                    code = alu_op_e'({2'b10, func3});
                else
                    illegal = 1'b1;
            end
            default: begin
                // Immediate ops: func7 only qualifies the shifts.
                if (func3 == 3'b001)
                    illegal = (func7 != F7_BASE);
                if (func3 == 3'b101 && func7 == F7_ALT)
                    code = ALU_SRA;
                else if (func3 == 3'b101 && func7 != F7_BASE)
                    illegal = 1'b1;
                else
                    code = base_op(func3);
            end
        endcase
        if (illegal)
            code = ALU_ADD;
        is_multi = !illegal && code[4];
    end

endmodule

// File: rtl/alu_md_seq.sv
// Sequential RV32I/RV32M ALU behind a valid/ready handshake. Base ops finish
// in one cycle; MUL/DIV/REM iterate one bit per cycle on operand magnitudes.
module alu_md_seq
    import alu_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int EN_M = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [1:0]      alu_op,
    input  logic [6:0]      func7,
    input  logic [2:0]      func3,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic [4:0]      alu_code,
    output logic            illegal
);

    localparam int              SHW       = $clog2(XLEN);
    localparam logic [XLEN-1:0] MOST_NEG  = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [SHW-1:0]  LAST_STEP = SHW'(XLEN - 1);

    alu_op_e dec_code;
    logic    dec_multi, dec_illegal;

    alu_md_decode #(.EN_M(EN_M)) u_decode (
        .alu_op   (alu_op),
        .func7    (func7),
        .func3    (func3),
        .code     (dec_code),
        .is_multi (dec_multi),
        .illegal  (dec_illegal)
    );

    state_e          state_q, state_d;
    logic [SHW-1:0]  count_q;
    logic [XLEN-1:0] hi_q, lo_q, opnd_q, result_q;
    logic            neg_quo_q, neg_rem_q, illegal_q;
    alu_op_e         code_q;

    logic [SHW-1:0]  shamt;
    logic [XLEN-1:0] quick_res;
    logic            quick_done;

    assign shamt = op_b[SHW-1:0];

    // Single-cycle results plus the divide-by-zero / overflow short-circuits.
    always_comb begin
        quick_res  = '0;
        quick_done = !dec_multi;
        case (dec_code)
            ALU_ADD:  quick_res = op_a + op_b;
            ALU_SUB:  quick_res = op_a - op_b;
            ALU_SLL:  quick_res = op_a << shamt;
            ALU_SLT:  quick_res = {{(XLEN-1){1'b0}}, $signed(op_a) < $signed(op_b)};
            ALU_SLTU: quick_res = {{(XLEN-1){1'b0}}, op_a < op_b};
            ALU_XOR:  quick_res = op_a ^ op_b;
            ALU_SRL:  quick_res = op_a >> shamt;
            ALU_SRA:  quick_res = $unsigned($signed(op_a) >>> shamt);
            ALU_OR:   quick_res = op_a | op_b;
            ALU_AND:  quick_res = op_a & op_b;
            ALU_DIV, ALU_REM: begin
                if (op_b == '0) begin
                    quick_done = 1'b1;
                    quick_res  = (dec_code == ALU_DIV) ? '1 : op_a;
                end else if (op_a == MOST_NEG && op_b == '1) begin
                    quick_done = 1'b1;
                    quick_res  = (dec_code == ALU_DIV) ? op_a : '0;
                end
            end
            ALU_DIVU, ALU_REMU: begin
                if (op_b == '0) begin
                    quick_done = 1'b1;
                    quick_res  = (dec_code == ALU_DIVU) ? '1 : op_a;
                end
            end
            default: ;
        endcase
        if (dec_illegal)
            quick_res = '0;
    end

    logic            a_neg, b_neg;
    logic [XLEN-1:0] a_mag, b_mag;

    // Operand signs (per op signedness) and magnitudes for the iterative engine.
    always_comb begin
        a_neg = 1'b0;
        b_neg = 1'b0;
        case (dec_code)
            ALU_MULH, ALU_DIV, ALU_REM: begin
                a_neg = op_a[XLEN-1];
                b_neg = op_b[XLEN-1];
            end
            ALU_MULHSU: a_neg = op_a[XLEN-1];
            default: ;
        endcase
        a_mag = a_neg ? -op_a : op_a;
        b_mag = b_neg ? -op_b : op_b;
    end

    logic [XLEN:0]   mul_sum;
    logic [XLEN+1:0] div_trial, div_diff;
    logic [XLEN-1:0] hi_step, lo_step;

    // One shift-add (mul) or restoring-subtract (div) step.
    always_comb begin
        hi_step   = hi_q;
        lo_step   = lo_q;
        mul_sum   = '0;
        div_trial = '0;
        div_diff  = '0;
        if (is_div(code_q)) begin
            div_trial = {1'b0, hi_q, lo_q[XLEN-1]};
            div_diff  = div_trial - {2'b00, opnd_q};
            if (!div_diff[XLEN+1]) begin
                hi_step = div_diff[XLEN-1:0];
                lo_step = {lo_q[XLEN-2:0], 1'b1};
            end else begin
                hi_step = div_trial[XLEN-1:0];
                lo_step = {lo_q[XLEN-2:0], 1'b0};
            end
        end else begin
            mul_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
            hi_step = mul_sum[XLEN:1];
            lo_step = {mul_sum[0], lo_q[XLEN-1:1]};
        end
    end

    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   final_res;

    // Sign fixup and result selection applied on the last step.
    always_comb begin
        prod = neg_quo_q ? -{hi_step, lo_step} : {hi_step, lo_step};
        case (code_q)
            ALU_MUL:                         final_res = prod[XLEN-1:0];
            ALU_MULH, ALU_MULHSU, ALU_MULHU: final_res = prod[2*XLEN-1:XLEN];
            ALU_DIV, ALU_DIVU:               final_res = neg_quo_q ? -lo_step : lo_step;
            ALU_REM, ALU_REMU:               final_res = neg_rem_q ? -hi_step : hi_step;
            default:                         final_res = '0;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values, independent of block order.
        if (!rst_n)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    // FSM next state and handshake outputs.
    always_comb begin
        state_d   = state_q;
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == DONE);
        case (state_q)
            IDLE:    if (in_valid) state_d = quick_done ? DONE : BUSY;
            BUSY:    if (count_q == LAST_STEP) state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Operand capture, iteration registers and the held result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the datapath registers are reset too, because the held
            // result, code and illegal flag have defined values out of reset.
            count_q   <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            opnd_q    <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            result_q  <= '0;
            code_q    <= ALU_ADD;
            illegal_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (in_valid) begin
                    code_q    <= dec_code;
                    illegal_q <= dec_illegal;
                    count_q   <= '0;
                    hi_q      <= '0;
                    lo_q      <= is_div(dec_code) ? a_mag : b_mag;
                    opnd_q    <= is_div(dec_code) ? b_mag : a_mag;
                    neg_quo_q <= a_neg ^ b_neg;
                    neg_rem_q <= a_neg;
                    if (quick_done)
                        result_q <= quick_res;
                end
                BUSY: begin
                    hi_q    <= hi_step;
                    lo_q    <= lo_step;
                    count_q <= count_q + SHW'(1);
                    if (count_q == LAST_STEP)
                        result_q <= final_res;
                end
                default: ;
            endcase
        end
    end

    assign result   = result_q;
    assign alu_code = code_q;
    assign illegal  = illegal_q;

endmodule
